layer_arbiter: RTL and testbench

LAYER_ARBITER -- requirements
Module: layer_arbiter

---
 rtl/layer_arb_pkg.sv | 17 +
 rtl/layer_arb_cfg.sv | 101 ++++++++++
 rtl/layer_arbiter.sv | 123 ++++++++++++
 tb/tb_layer_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/layer_arb_pkg.sv
// Shared constants for the layer arbiter: config map, reset values, field widths.
package layer_arb_pkg;

    localparam int CFG_ADDR_W  = 2;
    localparam int CFG_DATA_W  = 16;
    localparam int PRIO_W      = 8;
    localparam int MAX_LAYERS  = 4;
    localparam int FRAME_CNT_W = 6;

    localparam logic [CFG_ADDR_W-1:0] ADDR_EN    = 2'd0;
    localparam logic [CFG_ADDR_W-1:0] ADDR_PRIO  = 2'd1;
    localparam logic [CFG_ADDR_W-1:0] ADDR_BG    = 2'd2;
    localparam logic [CFG_ADDR_W-1:0] ADDR_BLINK = 2'd3;

    localparam logic [PRIO_W-1:0] PRIO_RST = 8'hE4;

endpackage

// File: rtl/layer_arb_cfg.sv
// Shadow/active config banks, write handshake, VS-fall commit, blink counter.
// Blink support is built only when LAYER_ARBITER_BLINK_EN is defined.
import layer_arb_pkg::*;

module layer_arb_cfg #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  vs_i,
    input  logic                  cfg_valid_i,
    input  logic [CFG_ADDR_W-1:0] cfg_addr_i,
    input  logic [CFG_DATA_W-1:0] cfg_data_i,
    output logic                  cfg_ready_o,
    output logic [NUM_LAYERS-1:0] en_o,
    output logic [PRIO_W-1:0]     prio_o,
    output logic [COLOR_W-1:0]    bg_o,
    output logic [NUM_LAYERS-1:0] hide_o
);

    logic vs_q;
    logic rdy_q;
    logic commit;
    logic wr;
    logic unused_data;

    logic [NUM_LAYERS-1:0] en_sq, en_aq;
    logic [PRIO_W-1:0]     prio_sq, prio_aq;
    logic [COLOR_W-1:0]    bg_sq, bg_aq;

    assign commit      = ~vs_i & vs_q;
    assign cfg_ready_o = rdy_q & ~commit;
    assign wr          = cfg_valid_i & cfg_ready_o;
    assign unused_data = ^cfg_data_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vs_q  <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            vs_q  <= vs_i;
            rdy_q <= 1'b1;
        end
    end

    // Writes and commits are mutually exclusive: ready drops in commit cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            en_sq   <= '1;
            prio_sq <= PRIO_RST;
            bg_sq   <= '1;
            en_aq   <= '1;
            prio_aq <= PRIO_RST;
            bg_aq   <= '1;
        end else begin
            if (wr) begin
                case (cfg_addr_i)
                    ADDR_EN:   en_sq   <= cfg_data_i[NUM_LAYERS-1:0];
                    ADDR_PRIO: prio_sq <= cfg_data_i[PRIO_W-1:0];
                    ADDR_BG:   bg_sq   <= cfg_data_i[COLOR_W-1:0];
                    default:   ;
                endcase
            end
            if (commit) begin
                en_aq   <= en_sq;
                prio_aq <= prio_sq;
                bg_aq   <= bg_sq;
            end
        end
    end

    assign en_o   = en_aq;
    assign prio_o = prio_aq;
    assign bg_o   = bg_aq;

`ifdef LAYER_ARBITER_BLINK_EN
    logic [NUM_LAYERS-1:0]  blink_sq, blink_aq;
    logic [FRAME_CNT_W-1:0] frame_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            blink_sq <= '0;
            blink_aq <= '0;
            frame_q  <= '0;
        end else begin
            if (wr && cfg_addr_i == ADDR_BLINK)
                blink_sq <= cfg_data_i[NUM_LAYERS-1:0];
            if (commit) begin
                blink_aq <= blink_sq;
                frame_q  <= frame_q + 1'b1;
            end
        end
    end

    assign hide_o = frame_q[FRAME_CNT_W-1] ? blink_aq : '0;
`else
    assign hide_o = '0;
`endif

endmodule

// File: rtl/layer_arbiter.sv
// Two-stage pixel pipeline choosing the highest-priority visible layer.
// Optional blink feature: define LAYER_ARBITER_BLINK_EN.
import layer_arb_pkg::*;

module layer_arbiter #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 10
) (
    input  logic                          iCLK_27MHz,
    input  logic                          ireset_n,
    input  logic [NUM_LAYERS-1:0]         iLAYER_ON,
    input  logic [NUM_LAYERS*COLOR_W-1:0] iLAYER_RGB,
    input  logic                          iVGA_ACTIVE,
    input  logic                          iVGA_HS,
    input  logic                          iVGA_VS,
    input  logic                          iCFG_VALID,
    input  logic [CFG_ADDR_W-1:0]         iCFG_ADDR,
    input  logic [CFG_DATA_W-1:0]         iCFG_DATA,
    output logic                          oCFG_READY,
    output logic [COLOR_W-1:0]            oVGA_R,
    output logic [COLOR_W-1:0]            oVGA_G,
    output logic [COLOR_W-1:0]            oVGA_B,
    output logic                          oVGA_ACTIVE,
    output logic                          oVGA_HS,
    output logic                          oVGA_VS,
    output logic [NUM_LAYERS-1:0]         oLAYER_HIT
);

    logic [NUM_LAYERS-1:0] en, hide;
    logic [PRIO_W-1:0]     prio;
    logic [COLOR_W-1:0]    bg;

    layer_arb_cfg #(
        .NUM_LAYERS(NUM_LAYERS),
        .COLOR_W   (COLOR_W)
    ) u_cfg (
        .clk_i      (iCLK_27MHz),
        .rst_ni     (ireset_n),
        .vs_i       (iVGA_VS),
        .cfg_valid_i(iCFG_VALID),
        .cfg_addr_i (iCFG_ADDR),
        .cfg_data_i (iCFG_DATA),
        .cfg_ready_o(oCFG_READY),
        .en_o       (en),
        .prio_o     (prio),
        .bg_o       (bg),
        .hide_o     (hide)
    );

    logic [NUM_LAYERS-1:0]         on_q;
    logic [NUM_LAYERS*COLOR_W-1:0] rgb_q;
    logic                          act_q, hs_q, vs_q;

    logic [COLOR_W-1:0]    pix_d, pix_q;
    logic [NUM_LAYERS-1:0] hit_d, hit_q;
    logic                  act2_q, hs2_q, vs2_q;

    logic [MAX_LAYERS-1:0] elig;
    logic [MAX_LAYERS-1:0] hit4;
    logic [COLOR_W-1:0]    lay [MAX_LAYERS];
    logic [1:0]            idx, win;
    logic                  found;

    // Padding to MAX_LAYERS makes out-of-range rank indices never eligible.
    always_comb begin
        elig = '0;
        elig[NUM_LAYERS-1:0] = en & on_q & ~hide;
        for (int k = 0; k < MAX_LAYERS; k++) lay[k] = '0;
        for (int k = 0; k < NUM_LAYERS; k++) lay[k] = rgb_q[k*COLOR_W +: COLOR_W];
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int r = 0; r < MAX_LAYERS; r++) begin
            idx = prio[2*r +: 2];
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        hit4  = found ? (4'b0001 << win) : 4'b0000;
        pix_d = found ? lay[win] : bg;
        hit_d = hit4[NUM_LAYERS-1:0];
        if (!act_q) begin
            pix_d = '0;
            hit_d = '0;
        end
    end

    always_ff @(posedge iCLK_27MHz) begin
        if (!ireset_n) begin
            on_q   <= '0;
            rgb_q  <= '0;
            act_q  <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            pix_q  <= '0;
            hit_q  <= '0;
            act2_q <= 1'b0;
            hs2_q  <= 1'b0;
            vs2_q  <= 1'b0;
        end else begin
            on_q   <= iLAYER_ON;
            rgb_q  <= iLAYER_RGB;
            act_q  <= iVGA_ACTIVE;
            hs_q   <= iVGA_HS;
            vs_q   <= iVGA_VS;
            pix_q  <= pix_d;
            hit_q  <= hit_d;
            act2_q <= act_q;
            hs2_q  <= hs_q;
            vs2_q  <= vs_q;
        end
    end

    assign oVGA_R      = pix_q;
    assign oVGA_G      = pix_q;
    assign oVGA_B      = pix_q;
    assign oLAYER_HIT  = hit_q;
    assign oVGA_ACTIVE = act2_q;
    assign oVGA_HS     = hs2_q;
    assign oVGA_VS     = vs2_q;

endmodule

// File: tb/tb_layer_arbiter.sv
// Directed self-checking bench for layer_arbiter.
// Blink checks compile in when LAYER_ARBITER_BLINK_EN is defined.
module tb_layer_arbiter;

    localparam int NL = 4;
    localparam int CW = 10;

    localparam logic [CW-1:0] L0 = 10'h011;
    localparam logic [CW-1:0] L1 = 10'h022;
    localparam logic [CW-1:0] L2 = 10'h033;
    localparam logic [CW-1:0] L3 = 10'h044;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NL-1:0]    on;
    logic [NL*CW-1:0] rgb;
    logic             act, hs, vs;
    logic             valid;
    logic [1:0]       addr;
    logic [15:0]      data;
    logic             ready;
    logic [CW-1:0]    r_o, g_o, b_o;
    logic             act_o, hs_o, vs_o;
    logic [NL-1:0]    hit;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    layer_arbiter #(.NUM_LAYERS(NL), .COLOR_W(CW)) dut (
        .iCLK_27MHz (clk),
        .ireset_n   (rst_n),
        .iLAYER_ON  (on),
        .iLAYER_RGB (rgb),
        .iVGA_ACTIVE(act),
        .iVGA_HS    (hs),
        .iVGA_VS    (vs),
        .iCFG_VALID (valid),
        .iCFG_ADDR  (addr),
        .iCFG_DATA  (data),
        .oCFG_READY (ready),
        .oVGA_R     (r_o),
        .oVGA_G     (g_o),
        .oVGA_B     (b_o),
        .oVGA_ACTIVE(act_o),
        .oVGA_HS    (hs_o),
        .oVGA_VS    (vs_o),
        .oLAYER_HIT (hit)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        valid = 1'b1;
        addr  = a;
        data  = d;
        step();
        valid = 1'b0;
    endtask

    task automatic commit();
        vs = 1'b1;
        step();
        vs = 1'b0;
        step();
        vs = 1'b1;
        step(2);
    endtask

    initial begin
        rst_n = 1'b0;
        on    = '0;
        rgb   = {L3, L2, L1, L0};
        act   = 1'b0;
        hs    = 1'b0;
        vs    = 1'b1;
        valid = 1'b0;
        addr  = '0;
        data  = '0;
        step(2);
        check("rst_pix", 32'(r_o), 32'(0));
        check("rst_hit", 32'(hit), 32'(0));
        check("rst_ready", 32'(ready), 32'(0));
        check("rst_act", 32'(act_o), 32'(0));

        rst_n = 1'b1;
        step();
        check("ready_up", 32'(ready), 32'(1));

        // layers 0 and 2 on: layer 0 wins after two cycles
        on  = 4'b0101;
        act = 1'b1;
        hs  = 1'b1;
        step();
        check("lat1_hit", 32'(hit), 32'(0));
        step();
        check("l0_r", 32'(r_o), 32'(L0));
        check("l0_g", 32'(g_o), 32'(L0));
        check("l0_b", 32'(b_o), 32'(L0));
        check("l0_hit", 32'(hit), 32'(4'b0001));
        check("act_o", 32'(act_o), 32'(1));
        check("hs_o", 32'(hs_o), 32'(1));

        // priority 1B staged mid-frame, takes effect at VS fall
        on = 4'b1001;
        cfg_write(2'd1, 16'h001B);
        step(2);
        check("prio_pend_hit", 32'(hit), 32'(4'b0001));
        check("prio_pend_r", 32'(r_o), 32'(L0));
        vs = 1'b0;
        #1;
        check("ready_commit", 32'(ready), 32'(0));
        step();
        check("ready_post", 32'(ready), 32'(1));
        check("vs_o_hi", 32'(vs_o), 32'(1));
        check("old_prio_hit", 32'(hit), 32'(4'b0001));
        step();
        check("new_prio_hit", 32'(hit), 32'(4'b1000));
        check("new_prio_r", 32'(r_o), 32'(L3));
        check("vs_o_lo", 32'(vs_o), 32'(0));

        // valid held across VS fall: accepted one cycle later
        vs = 1'b1;
        on = '0;
        step();
        vs    = 1'b0;
        valid = 1'b1;
        addr  = 2'd2;
        data  = 16'h02AA;
        #1;
        check("hold_ready0", 32'(ready), 32'(0));
        step();
        check("hold_ready1", 32'(ready), 32'(1));
        step();
        valid = 1'b0;
        step(2);
        check("bg_pend", 32'(r_o), 32'(10'h3FF));
        check("bg_pend_hit", 32'(hit), 32'(0));
        commit();
        check("bg_2aa", 32'(r_o), 32'(10'h2AA));

        // duplicate ranks, upper data bits ignored: prio 0A
        cfg_write(2'd1, 16'hA50A);
        commit();
        on = 4'b0001;
        step(2);
        check("dup_l0_hit", 32'(hit), 32'(4'b0001));
        check("dup_l0_r", 32'(r_o), 32'(L0));
        on = 4'b0101;
        step(2);
        check("dup_l2_hit", 32'(hit), 32'(4'b0100));
        check("dup_l2_r", 32'(r_o), 32'(L2));
        on = 4'b0010;
        step(2);
        check("unranked_hit", 32'(hit), 32'(0));
        check("unranked_r", 32'(r_o), 32'(10'h2AA));

        // all disabled: background only, then blanked when inactive
        cfg_write(2'd0, 16'h0000);
        cfg_write(2'd2, 16'h0155);
        on = 4'b1111;
        commit();
        check("dis_r", 32'(r_o), 32'(10'h155));
        check("dis_b", 32'(b_o), 32'(10'h155));
        check("dis_hit", 32'(hit), 32'(0));
        act = 1'b0;
        step(2);
        check("inact_r", 32'(r_o), 32'(0));
        check("inact_hit", 32'(hit), 32'(0));
        check("inact_act", 32'(act_o), 32'(0));

        // reset discards staged background 0
        act = 1'b1;
        on  = '0;
        cfg_write(2'd2, 16'h0000);
        rst_n = 1'b0;
        step();
        check("mid_rst_r", 32'(r_o), 32'(0));
        check("mid_rst_ready", 32'(ready), 32'(0));
        rst_n = 1'b1;
        step();
        commit();
        check("rst_bg", 32'(r_o), 32'(10'h3FF));
        on = 4'b0100;
        step(2);
        check("rst_prio_hit", 32'(hit), 32'(4'b0100));
        check("rst_prio_r", 32'(r_o), 32'(L2));

`ifdef LAYER_ARBITER_BLINK_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        on = 4'b0001;
        cfg_write(2'd3, 16'h0001);
        commit();
        for (int f = 1; f <= 64; f++) begin
            check($sformatf("blink_f%0d", f % 64), 32'(r_o),
                  ((f % 64) < 32) ? 32'(L0) : 32'(10'h3FF));
            if (f < 64) commit();
        end
`else
        on = 4'b0001;
        cfg_write(2'd3, 16'h000F);
        commit();
        check("noblink_r", 32'(r_o), 32'(L0));
        check("noblink_hit", 32'(hit), 32'(4'b0001));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
